axi_slave_read_responder: RTL and testbench

AXI slave-side read responder for the FIFO/BFM test environment. It accepts read-address requests on the AR channel, fetches each beat from a synchronous backing memory, and returns data and responses on the R channel. It serves as the counterpart to the master read controller in loopback benches and as the read port of the slave BFM.

---
 rtl/axi_pkg.sv | 20 ++
 rtl/axi_rd_addr_gen.sv | 32 +++
 rtl/axi_slave_read_responder.sv | 145 ++++++++++++++
 tb/tb_axi_slave_read_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI encodings: burst types, response codes, read FSM states
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_SEND
    } rd_state_t;

endpackage

// File: rtl/axi_rd_addr_gen.sv
// rtl/axi_rd_addr_gen.sv - combinational next-beat address for FIXED/INCR/WRAP bursts
module axi_rd_addr_gen
    import axi_pkg::*;
#(
    parameter int addr_width = 32
) (
    input  logic [addr_width-1:0] i_addr,
    input  logic [2:0]            i_size,
    input  logic [7:0]            i_len,
    input  logic [1:0]            i_burst,
    output logic [addr_width-1:0] o_next_addr
);

    logic [addr_width-1:0] w_inc;
    logic [addr_width-1:0] w_sum;
    logic [addr_width-1:0] w_bound_mask;

    assign w_inc        = addr_width'(1) << i_size;
    assign w_sum        = i_addr + w_inc;
    // wrap boundary is (len+1) beats of inc bytes; len is pre-validated as 1/3/7/15
    assign w_bound_mask = ((addr_width'(i_len) + addr_width'(1)) << i_size) - addr_width'(1);

    always_comb begin
        o_next_addr = i_addr;
        case (i_burst)
            BURST_INCR: o_next_addr = w_sum;
            BURST_WRAP: o_next_addr = (i_addr & ~w_bound_mask) | (w_sum & w_bound_mask);
            default:    o_next_addr = i_addr;
        endcase
    end

endmodule

// File: rtl/axi_slave_read_responder.sv
// rtl/axi_slave_read_responder.sv - AXI slave read responder backed by a synchronous memory
module axi_slave_read_responder
    import axi_pkg::*;
#(
    parameter int addr_width = 32,
    parameter int data_width = 64,
    parameter int mem_aw     = 8
) (
    input  logic                  AClk,
    input  logic                  ARst,
    input  logic [7:0]            ARID,
    input  logic [addr_width-1:0] ARADDR,
    input  logic [7:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic [1:0]            ARBURST,
    input  logic [1:0]            ARLOCK,
    input  logic [1:0]            ARCACHE,
    input  logic [2:0]            ARPROT,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [7:0]            RID,
    output logic [data_width-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic                  mem_rd_en,
    output logic [mem_aw-1:0]     mem_rd_addr,
    input  logic [data_width-1:0] mem_rd_data
);

    localparam int BYTE_SHIFT = $clog2(data_width / 8);

    rd_state_t             r_state, w_next_state;
    logic [addr_width-1:0] r_addr;
    logic [7:0]            r_id, r_len, r_beat_cnt;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_slverr, r_decerr;
    logic                  r_arready, r_rvalid, r_rlast, r_mem_rd_en;
    logic [1:0]            r_rresp;
    logic [data_width-1:0] r_rdata;
    logic [mem_aw-1:0]     r_mem_rd_addr;

    logic                  w_ar_hs, w_r_hs, w_ar_err, w_start_fetch;
    logic                  w_fetch_err, w_fetch_dec;
    logic [addr_width-1:0] w_next_addr, w_fetch_addr, w_word;
    logic                  w_unused_ar;

    assign w_unused_ar = ^{ARLOCK, ARCACHE, ARPROT};

    assign w_ar_hs  = ARVALID && r_arready && (r_state == ST_IDLE);
    assign w_r_hs   = r_rvalid && RREADY;
    assign w_ar_err = (int'(ARSIZE) > BYTE_SHIFT) || (ARBURST == BURST_RSVD) ||
                      ((ARBURST == BURST_WRAP) && !(ARLEN inside {8'd1, 8'd3, 8'd7, 8'd15}));

    axi_rd_addr_gen #(.addr_width(addr_width)) u_addr_gen (
        .i_addr      (r_addr),
        .i_size      (r_size),
        .i_len       (r_len),
        .i_burst     (r_burst),
        .o_next_addr (w_next_addr)
    );

    // the beat being launched uses ARADDR on the first beat, the advanced address afterwards
    assign w_start_fetch = w_ar_hs || (w_r_hs && !r_rlast);
    assign w_fetch_addr  = (r_state == ST_IDLE) ? ARADDR : w_next_addr;
    assign w_fetch_err   = (r_state == ST_IDLE) ? w_ar_err : r_slverr;
    assign w_word        = w_fetch_addr >> BYTE_SHIFT;
    assign w_fetch_dec   = |(w_word >> mem_aw);

    always_ff @(posedge AClk) begin
        if (!ARst) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_ar_hs) w_next_state = ST_FETCH;
            ST_FETCH: w_next_state = ST_WAIT;
            ST_WAIT:  w_next_state = ST_SEND;
            ST_SEND:  if (w_r_hs) w_next_state = r_rlast ? ST_IDLE : ST_FETCH;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge AClk) begin
        if (!ARst) begin
            r_arready     <= 1'b0;
            r_rvalid      <= 1'b0;
            r_rlast       <= 1'b0;
            r_rresp       <= RESP_OKAY;
            r_rdata       <= '0;
            r_id          <= '0;
            r_mem_rd_en   <= 1'b0;
            r_mem_rd_addr <= '0;
            r_addr        <= '0;
            r_len         <= '0;
            r_beat_cnt    <= '0;
            r_size        <= '0;
            r_burst       <= BURST_FIXED;
            r_slverr      <= 1'b0;
            r_decerr      <= 1'b0;
        end else begin
            r_arready   <= (w_next_state == ST_IDLE);
            r_mem_rd_en <= w_start_fetch && !w_fetch_err && !w_fetch_dec;
            if (w_start_fetch) begin
                r_mem_rd_addr <= w_word[mem_aw-1:0];
                r_decerr      <= w_fetch_dec;
            end
            if (w_ar_hs) begin
                r_id       <= ARID;
                r_addr     <= ARADDR;
                r_len      <= ARLEN;
                r_beat_cnt <= ARLEN;
                r_size     <= ARSIZE;
                r_burst    <= ARBURST;
                r_slverr   <= w_ar_err;
            end else if (w_r_hs && !r_rlast) begin
                r_addr     <= w_next_addr;
                r_beat_cnt <= r_beat_cnt - 8'd1;
            end
            // memory data lands during WAIT; R outputs then freeze until accepted
            if (r_state == ST_WAIT) begin
                r_rvalid <= 1'b1;
                r_rlast  <= (r_beat_cnt == 8'd0);
                r_rdata  <= (r_slverr || r_decerr) ? '0 : mem_rd_data;
                r_rresp  <= r_slverr ? RESP_SLVERR : (r_decerr ? RESP_DECERR : RESP_OKAY);
            end else if (w_r_hs) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign ARREADY     = r_arready;
    assign RID         = r_id;
    assign RDATA       = r_rdata;
    assign RRESP       = r_rresp;
    assign RLAST       = r_rlast;
    assign RVALID      = r_rvalid;
    assign mem_rd_en   = r_mem_rd_en;
    assign mem_rd_addr = r_mem_rd_addr;

endmodule

// File: tb/tb_axi_slave_read_responder.sv
// tb/tb_axi_slave_read_responder.sv - scoreboard bench for axi_slave_read_responder
module tb_axi_slave_read_responder;

    logic        AClk = 1'b0;
    logic        ARst;
    logic [7:0]  ARID;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic [1:0]  ARLOCK, ARCACHE;
    logic [2:0]  ARPROT;
    logic        ARVALID, ARREADY;
    logic [7:0]  RID;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST, RVALID, RREADY;
    logic        mem_rd_en;
    logic [7:0]  mem_rd_addr;
    logic [63:0] mem_rd_data;

    always #5 AClk = ~AClk;

    axi_slave_read_responder #(.addr_width(32), .data_width(64), .mem_aw(8)) dut (
        .AClk(AClk), .ARst(ARst), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE),
        .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY), .RID(RID),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
    );

    // backing memory: word k holds k
    always @(posedge AClk) if (mem_rd_en) mem_rd_data <= {56'd0, mem_rd_addr};

    typedef struct packed {
        logic [7:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t      sbq[$];
    logic [7:0] memq[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push_beat(input logic [7:0] id, input logic [63:0] d, input logic [1:0] r, input logic l);
        beat_t b;
        b.id = id; b.data = d; b.resp = r; b.last = l;
        sbq.push_back(b);
    endtask

    always @(negedge AClk) begin
        if (RVALID && RREADY) begin
            if (sbq.size() == 0) begin
                chk("unexpected_beat", {56'd0, RID}, 64'hFFFF);
            end else begin
                beat_t b;
                b = sbq.pop_front();
                chk("rid",   {56'd0, RID},   {56'd0, b.id});
                chk("rdata", RDATA,          b.data);
                chk("rresp", {62'd0, RRESP}, {62'd0, b.resp});
                chk("rlast", {63'd0, RLAST}, {63'd0, b.last});
            end
        end
        if (mem_rd_en) begin
            if (memq.size() == 0) chk("unexpected_mem_rd", {56'd0, mem_rd_addr}, 64'hFFFF);
            else chk("mem_rd_addr", {56'd0, mem_rd_addr}, {56'd0, memq.pop_front()});
        end
    end

    task automatic tick();
        @(posedge AClk);
        #1;
    endtask

    task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int cyc = 0;
        while (!ARREADY && cyc < 50) begin tick(); cyc++; end
        chk("arready_wait", {63'd0, ARREADY}, 64'd1);
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
        ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        while ((sbq.size() != 0 || RVALID) && cyc < 300) begin tick(); cyc++; end
        chk(name, 64'(sbq.size() + memq.size()), 64'd0);
    endtask

    task automatic wait_rvalid();
        int cyc = 0;
        while (!RVALID && cyc < 50) begin tick(); cyc++; end
        chk("rvalid_wait", {63'd0, RVALID}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] hold_d;
        logic        hold_l;
        ARst = 1'b0; RREADY = 1'b1; ARVALID = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;
        ARLOCK = '0; ARCACHE = '0; ARPROT = '0;
        repeat (3) tick();
        chk("rst_arready",  {63'd0, ARREADY},   64'd0);
        chk("rst_rvalid",   {63'd0, RVALID},    64'd0);
        chk("rst_rlast",    {63'd0, RLAST},     64'd0);
        chk("rst_rresp",    {62'd0, RRESP},     64'd0);
        chk("rst_rid",      {56'd0, RID},       64'd0);
        chk("rst_rdata",    RDATA,              64'd0);
        chk("rst_mem_en",   {63'd0, mem_rd_en}, 64'd0);
        chk("rst_mem_addr", {56'd0, mem_rd_addr}, 64'd0);
        ARst = 1'b1;
        tick();
        chk("arready_after_rst", {63'd0, ARREADY}, 64'd1);

        // INCR 0x10, 4 beats of 8 bytes: words 2..5, with first-beat latency
        for (int k = 2; k < 6; k++) begin
            memq.push_back(8'(k));
            push_beat(8'h5A, 64'(k), 2'b00, k == 5);
        end
        send_ar(8'h5A, 32'h10, 8'd3, 3'd3, 2'b01);
        chk("lat_mem_en_n1",  {63'd0, mem_rd_en}, 64'd1);
        chk("lat_arready_n1", {63'd0, ARREADY},   64'd0);
        chk("lat_rvalid_n1",  {63'd0, RVALID},    64'd0);
        tick();
        chk("lat_mem_en_n2",  {63'd0, mem_rd_en}, 64'd0);
        chk("lat_rvalid_n2",  {63'd0, RVALID},    64'd0);
        tick();
        chk("lat_rvalid_n3",  {63'd0, RVALID},    64'd1);
        drain("incr_drain");

        // WRAP 0x18, 4 beats: words 3,0,1,2
        memq.push_back(8'd3); push_beat(8'h11, 64'd3, 2'b00, 1'b0);
        memq.push_back(8'd0); push_beat(8'h11, 64'd0, 2'b00, 1'b0);
        memq.push_back(8'd1); push_beat(8'h11, 64'd1, 2'b00, 1'b0);
        memq.push_back(8'd2); push_beat(8'h11, 64'd2, 2'b00, 1'b1);
        send_ar(8'h11, 32'h18, 8'd3, 3'd3, 2'b10);
        drain("wrap_drain");

        // FIXED 0x40, 3 beats: word 8 each time
        for (int k = 0; k < 3; k++) begin
            memq.push_back(8'd8);
            push_beat(8'h22, 64'd8, 2'b00, k == 2);
        end
        send_ar(8'h22, 32'h40, 8'd2, 3'd3, 2'b00);
        drain("fixed_drain");

        // RREADY held low for 5 cycles while beat 2 is presented
        for (int k = 0; k < 4; k++) begin
            memq.push_back(8'(k));
            push_beat(8'h33, 64'(k), 2'b00, k == 3);
        end
        RREADY = 1'b0;
        send_ar(8'h33, 32'h0, 8'd3, 3'd3, 2'b01);
        wait_rvalid();
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        wait_rvalid();
        hold_d = RDATA;
        hold_l = RLAST;
        chk("stall_beat2_data", hold_d, 64'd1);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("stall_rvalid", {63'd0, RVALID},    64'd1);
            chk("stall_rdata",  RDATA,              hold_d);
            chk("stall_rlast",  {63'd0, RLAST},     {63'd0, hold_l});
            chk("stall_mem_en", {63'd0, mem_rd_en}, 64'd0);
        end
        RREADY = 1'b1;
        drain("stall_drain");

        // oversize beat on a 64-bit bus: SLVERR, zero data, no memory reads
        push_beat(8'h44, 64'd0, 2'b10, 1'b0);
        push_beat(8'h44, 64'd0, 2'b10, 1'b1);
        send_ar(8'h44, 32'h0, 8'd1, 3'd4, 2'b01);
        drain("slverr_drain");

        // word 255 is in range, word 256 decodes nowhere
        memq.push_back(8'd255);
        push_beat(8'h55, 64'd255, 2'b00, 1'b0);
        push_beat(8'h55, 64'd0,   2'b11, 1'b1);
        send_ar(8'h55, 32'h7F8, 8'd1, 3'd3, 2'b01);
        drain("decerr_drain");

        // reset during beat 2 of an 8-beat burst
        memq.push_back(8'd0); memq.push_back(8'd1);
        push_beat(8'h66, 64'd0, 2'b00, 1'b0);
        send_ar(8'h66, 32'h0, 8'd7, 3'd3, 2'b01);
        begin
            int cyc = 0;
            while (sbq.size() != 0 && cyc < 50) begin tick(); cyc++; end
        end
        RREADY = 1'b0;
        wait_rvalid();
        ARst = 1'b0;
        tick();
        chk("midrst_rvalid",  {63'd0, RVALID},    64'd0);
        chk("midrst_arready", {63'd0, ARREADY},   64'd0);
        chk("midrst_rid",     {56'd0, RID},       64'd0);
        chk("midrst_mem_en",  {63'd0, mem_rd_en}, 64'd0);
        ARst = 1'b1;
        RREADY = 1'b1;
        tick();
        chk("postrst_arready", {63'd0, ARREADY}, 64'd1);
        repeat (6) begin
            tick();
            chk("postrst_no_beat", {63'd0, RVALID}, 64'd0);
        end
        chk("postrst_queues", 64'(sbq.size() + memq.size()), 64'd0);
        memq.push_back(8'd4); push_beat(8'h77, 64'd4, 2'b00, 1'b0);
        memq.push_back(8'd5); push_beat(8'h77, 64'd5, 2'b00, 1'b1);
        send_ar(8'h77, 32'h20, 8'd1, 3'd3, 2'b01);
        drain("postrst_drain");

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
